// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, ALU opcodes and stage-1 record for alu_arbiter
//
// Purpose: one place for the operand width, opcode width and opcode encodings
// used by the arbiter, its interface and the ALU that sits between the stages.
// Ports: none (package).
package alu_pkg;

  localparam int XLEN = 64;
  localparam int OPW  = 4;

  typedef logic [XLEN-1:0] word_t;
  typedef logic [OPW-1:0]  op_t;

  localparam op_t OP_ADD  = 4'd0;
  localparam op_t OP_SUB  = 4'd1;
  localparam op_t OP_AND  = 4'd2;
  localparam op_t OP_OR   = 4'd3;
  localparam op_t OP_XOR  = 4'd4;
  localparam op_t OP_SLL  = 4'd5;
  localparam op_t OP_SRL  = 4'd6;
  localparam op_t OP_SRA  = 4'd7;
  localparam op_t OP_SLT  = 4'd8;
  localparam op_t OP_SLTU = 4'd9;

  // Contents of the operand register: everything the ALU and the result
  // stage need to know about one granted request.
  typedef struct packed {
    word_t a;
    word_t b;
    op_t   op;
    logic  id;
  } s1_t;

  localparam s1_t S1_RESET = '{a: '0, b: '0, op: OP_ADD, id: 1'b0};

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request, shared-ALU and response signals of alu_arbiter
//
// Purpose: bundles the two-port request handshake, the operand/result path to
// the external ALU and the single response channel.
// Signals:
//   req_valid[1:0], req_ready[1:0]      per-port handshake, bit i = port i
//   req_a/req_b [2*XLEN], req_op [2*OPW] port i at [i*W +: W]
//   alu_a, alu_b, alu_op                 stage-1 operands to the ALU
//   alu_result                           combinational ALU result
//   rsp_valid, rsp_id, rsp_data, rsp_ready  response handshake
// Modports:
//   slave  - the arbiter side
//   master - requesters, ALU and response consumer
interface alu_arbiter_if
  import alu_pkg::*;
;

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [2*XLEN-1:0] req_a;
  logic [2*XLEN-1:0] req_b;
  logic [2*OPW-1:0]  req_op;

  word_t             alu_a;
  word_t             alu_b;
  op_t               alu_op;
  word_t             alu_result;

  logic              rsp_valid;
  logic              rsp_id;
  word_t             rsp_data;
  logic              rsp_ready;

  modport slave (
    input  req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
    output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_data
  );

  modport master (
    output req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// rtl/alu_arbiter_rr_arb2.sv - two-way round-robin grant with last-winner state
//
// Purpose: picks one of two requesters when enabled; on a tie the port that did
// not win last time gets the grant.
// Ports:
//   clk    in  1  rising-edge clock
//   rst_n  in  1  asynchronous active-low reset
//   en     in  1  grant allowed this cycle (stage 1 can take a request)
//   req    in  2  request bits, bit i = port i
//   grant  out 2  one-hot or zero; every grant is a completed transfer
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  // Reset to 1 so port 0 wins the first tie.
  logic rr_last_q;
  logic rr_last_d;
  logic [1:0] grant_c;

  always_comb begin
    grant_c = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   grant_c = 2'b01;
        2'b10:   grant_c = 2'b10;
        2'b11:   grant_c = rr_last_q ? 2'b01 : 2'b10;
        default: grant_c = 2'b00;
      endcase
    end
  end

  // A grant is only raised against a valid request, so any grant is a transfer.
  always_comb begin
    rr_last_d = rr_last_q;
    if (grant_c[0]) begin
      rr_last_d = 1'b0;
    end else if (grant_c[1]) begin
      rr_last_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q <= 1'b1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

  assign grant = grant_c;

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port round-robin front end for one shared combinational ALU
//
// Purpose: accepts operations from two ports, registers the winner's operands
// (stage 1, driving the external ALU) and then registers the ALU result
// (stage 2, the response). Latency 2, one result per cycle when unstalled.
// Ports:
//   clk    in  1  rising-edge clock
//   rst_n  in  1  asynchronous active-low reset; drops all in-flight work
//   bus    slave modport of alu_arbiter_if (requests, ALU path, response)
module alu_arbiter
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  s1_t   s1_q, s1_d;
  logic  s1_valid_q, s1_valid_d;
  logic  rsp_valid_q, rsp_valid_d;
  logic  rsp_id_q, rsp_id_d;
  word_t rsp_data_q, rsp_data_d;

  logic       s2_free;
  logic       s1_adv;
  logic       s1_free;
  logic [1:0] grant;
  logic       accept;

  // rsp_ready reaches req_ready only through s2_free.
  assign s2_free = !rsp_valid_q || bus.rsp_ready;
  assign s1_adv  = s1_valid_q && s2_free;
  assign s1_free = !s1_valid_q || s1_adv;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (s1_free),
    .req   (bus.req_valid),
    .grant (grant)
  );

  assign bus.req_ready = grant;
  assign accept        = |grant;

  // Stage 1: load the granted port's operands; otherwise hold, so the ALU
  // inputs never toggle while idle or stalled.
  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_d.id    = grant[1];
      s1_d.a     = grant[1] ? bus.req_a[2*XLEN-1:XLEN] : bus.req_a[XLEN-1:0];
      s1_d.b     = grant[1] ? bus.req_b[2*XLEN-1:XLEN] : bus.req_b[XLEN-1:0];
      s1_d.op    = grant[1] ? bus.req_op[2*OPW-1:OPW]  : bus.req_op[OPW-1:0];
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2: capture the ALU result when stage 1 advances; drop valid once
  // the consumer takes it and nothing follows.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (s1_adv) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = s1_q.id;
      rsp_data_d  = bus.alu_result;
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= S1_RESET;
      s1_valid_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      s1_q        <= s1_d;
      s1_valid_q  <= s1_valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.alu_a     = s1_q.a;
  assign bus.alu_b     = s1_q.b;
  assign bus.alu_op    = s1_q.op;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic  id;
    word_t data;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t obs_q[$];
  int   inflight;
  int   mdl_last;

  logic [1:0] smp_ready;
  logic       smp_rsp_valid;
  logic       smp_rsp_id;
  word_t      smp_rsp_data;
  word_t      smp_alu_a;

  function automatic word_t ref_alu(word_t a, word_t b, op_t op);
    int sh;
    sh = int'(b % 64);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << sh;
      OP_SRL:  return a >> sh;
      OP_SRA:  return word_t'($signed(a) >>> sh);
      OP_SLT:  return ($signed(a) < $signed(b)) ? word_t'(1) : word_t'(0);
      OP_SLTU: return (a < b) ? word_t'(1) : word_t'(0);
      default: return '0;
    endcase
  endfunction

  assign bus.alu_result = ref_alu(bus.alu_a, bus.alu_b, bus.alu_op);

  // One clock: sample just before the edge, log transfers into the model.
  task automatic tick();
    rsp_t r;
    #1;
    smp_ready     = bus.req_ready;
    smp_rsp_valid = bus.rsp_valid;
    smp_rsp_id    = bus.rsp_id;
    smp_rsp_data  = bus.rsp_data;
    smp_alu_a     = bus.alu_a;
    for (int i = 0; i < 2; i++) begin
      if (bus.req_valid[i] && bus.req_ready[i]) begin
        r.id   = 1'(i);
        r.data = ref_alu(bus.req_a[i*XLEN +: XLEN], bus.req_b[i*XLEN +: XLEN],
                         bus.req_op[i*OPW +: OPW]);
        exp_q.push_back(r);
        inflight++;
        mdl_last = i;
      end
    end
    if (bus.rsp_valid && bus.rsp_ready) begin
      r.id   = bus.rsp_id;
      r.data = bus.rsp_data;
      obs_q.push_back(r);
      inflight--;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_port(int p, word_t a, word_t b, op_t op);
    bus.req_a[p*XLEN +: XLEN] = a;
    bus.req_b[p*XLEN +: XLEN] = b;
    bus.req_op[p*OPW +: OPW]  = op;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    while (inflight > 0 && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    obs_q.delete();
    inflight = 0;
    mdl_last = 1;
  endtask

  task automatic do_reset();
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.req_valid = 2'b00;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_op = '0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data got %0h want 0", bus.rsp_data); end
    checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id got %0b want 0", bus.rsp_id); end
    checks++; if (bus.alu_a !== '0 || bus.alu_b !== '0) begin errors++; $display("FAIL reset_alu_ab got %0h/%0h want 0/0", bus.alu_a, bus.alu_b); end
    checks++; if (bus.alu_op !== OP_ADD) begin errors++; $display("FAIL reset_alu_op got %0d want %0d", bus.alu_op, OP_ADD); end
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b want 00", bus.req_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    bus.rsp_ready = 1'b1;
    set_port(0, 64'd123, 64'd456, OP_OR);
    bus.req_valid = 2'b01;
    tick();
    checks++; if (smp_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b want 01", smp_ready); end
    bus.req_valid = 2'b00;
    tick();
    checks++; if (smp_rsp_valid !== 1'b0 || smp_alu_a !== 64'd123) begin errors++; $display("FAIL single_stage1 got valid=%0b alu_a=%0d want 0/123", smp_rsp_valid, smp_alu_a); end
    tick();
    checks++; if (smp_rsp_valid !== 1'b1 || smp_rsp_id !== 1'b0 || smp_rsp_data !== 64'd507) begin
      errors++; $display("FAIL single_rsp got valid=%0b id=%0b data=%0d want 1/0/507", smp_rsp_valid, smp_rsp_id, smp_rsp_data);
    end
    drain();
    model_clear();
  endtask

  task automatic test_tie();
    rsp_t want[3];
    do_reset();
    bus.rsp_ready = 1'b1;
    set_port(0, -64'sd1111, 64'd2222, OP_OR);
    set_port(1, -64'sd3333, -64'sd4444, OP_OR);
    bus.req_valid = 2'b11;
    tick();
    checks++; if (smp_ready !== 2'b01) begin errors++; $display("FAIL tie_first got %b want 01", smp_ready); end
    set_port(0, 64'd5, 64'd10, OP_OR);
    tick();
    checks++; if (smp_ready !== 2'b10) begin errors++; $display("FAIL tie_second got %b want 10", smp_ready); end
    bus.req_valid = 2'b01;
    tick();
    checks++; if (smp_ready !== 2'b01) begin errors++; $display("FAIL tie_third got %b want 01", smp_ready); end
    drain();
    want[0] = '{id: 1'b0, data: -64'sd1105};
    want[1] = '{id: 1'b1, data: -64'sd257};
    want[2] = '{id: 1'b0, data: 64'd15};
    checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL tie_count got %0d want 3", obs_q.size()); end
    for (int k = 0; k < 3 && k < obs_q.size(); k++) begin
      checks++; if (obs_q[k] !== want[k]) begin errors++; $display("FAIL tie_rsp%0d got id=%0b data=%0h want id=%0b data=%0h", k, obs_q[k].id, obs_q[k].data, want[k].id, want[k].data); end
    end
    model_clear();
  endtask

  task automatic test_back_to_back();
    logic [1:0] rdy[7];
    logic       rv[7];
    logic       rid[7];
    word_t      rd[7];
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k < 4) begin
        set_port(1, word_t'(k + 1), word_t'(k + 1), OP_ADD);
        bus.req_valid = 2'b10;
      end else begin
        bus.req_valid = 2'b00;
      end
      tick();
      rdy[k] = smp_ready; rv[k] = smp_rsp_valid; rid[k] = smp_rsp_id; rd[k] = smp_rsp_data;
    end
    for (int k = 0; k < 4; k++) begin
      checks++; if (rdy[k] !== 2'b10) begin errors++; $display("FAIL b2b_ready%0d got %b want 10", k, rdy[k]); end
    end
    for (int k = 2; k < 6; k++) begin
      checks++; if (rv[k] !== 1'b1 || rid[k] !== 1'b1 || rd[k] !== word_t'(2 * (k - 1))) begin
        errors++; $display("FAIL b2b_rsp%0d got valid=%0b id=%0b data=%0d want 1/1/%0d", k, rv[k], rid[k], rd[k], 2 * (k - 1));
      end
    end
    checks++; if (rv[6] !== 1'b0) begin errors++; $display("FAIL b2b_idle got %0b want 0", rv[6]); end
    model_clear();
  endtask

  task automatic test_backpressure();
    int idx;
    int n;
    word_t first;
    idx = 0;
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      set_port(0, word_t'((idx + 1) * 10), word_t'(idx + 1), OP_ADD);
      bus.req_valid = (idx < 3) ? 2'b01 : 2'b00;
      tick();
      if (smp_ready[0]) idx++;
      if (c == 2) first = smp_rsp_data;
      if (c > 2) begin
        checks++; if (smp_rsp_data !== first || smp_rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_stable%0d got valid=%0b data=%0d want 1/%0d", c, smp_rsp_valid, smp_rsp_data, first); end
      end
    end
    checks++; if (idx != 2) begin errors++; $display("FAIL bp_inflight got %0d want 2", idx); end
    checks++; if (smp_ready !== 2'b00) begin errors++; $display("FAIL bp_ready got %b want 00", smp_ready); end
    checks++; if (first !== 64'd11) begin errors++; $display("FAIL bp_head got %0d want 11", first); end
    bus.rsp_ready = 1'b1;
    n = 0;
    while (idx < 3 && n < 20) begin
      set_port(0, word_t'((idx + 1) * 10), word_t'(idx + 1), OP_ADD);
      bus.req_valid = 2'b01;
      tick();
      if (smp_ready[0]) idx++;
      n++;
    end
    drain();
    checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL bp_count got %0d want 3", obs_q.size()); end
    for (int k = 0; k < 3 && k < obs_q.size(); k++) begin
      checks++; if (obs_q[k].data !== word_t'(11 * (k + 1)) || obs_q[k].id !== 1'b0) begin
        errors++; $display("FAIL bp_rsp%0d got id=%0b data=%0d want 0/%0d", k, obs_q[k].id, obs_q[k].data, 11 * (k + 1));
      end
    end
    model_clear();
  endtask

  task automatic test_async_reset();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 2'b10;
    for (int k = 0; k < 3; k++) begin
      set_port(1, word_t'({$urandom, $urandom}), word_t'({$urandom, $urandom}), OP_ADD);
      tick();
    end
    checks++; if (smp_rsp_valid !== 1'b1) begin errors++; $display("FAIL areset_pre got %0b want 1", smp_rsp_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== '0) begin errors++; $display("FAIL areset_now got valid=%0b data=%0h want 0/0", bus.rsp_valid, bus.rsp_data); end
    bus.req_valid = 2'b00;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    set_port(0, 64'd7, 64'd8, OP_ADD);
    set_port(1, 64'd9, 64'd1, OP_SUB);
    bus.req_valid = 2'b11;
    tick();
    checks++; if (smp_ready !== 2'b01) begin errors++; $display("FAIL areset_tie got %b want 01", smp_ready); end
    bus.req_valid = 2'b10;
    tick();
    drain();
    checks++; if (obs_q.size() != 2 || exp_q.size() != 2) begin errors++; $display("FAIL areset_count got %0d want 2", obs_q.size()); end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      checks++; if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL areset_rsp%0d got %0h want %0h", k, obs_q[k], exp_q[k]); end
    end
    model_clear();
  endtask

  task automatic test_wrap();
    bus.rsp_ready = 1'b1;
    set_port(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, OP_ADD);
    bus.req_valid = 2'b01;
    tick();
    set_port(0, 64'd3, 64'd65, OP_SLL);
    tick();
    drain();
    checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL wrap_count got %0d want 2", obs_q.size()); end
    if (obs_q.size() == 2) begin
      checks++; if (obs_q[0].data !== 64'd0) begin errors++; $display("FAIL wrap_add got %0h want 0", obs_q[0].data); end
      checks++; if (obs_q[1].data !== 64'd6) begin errors++; $display("FAIL wrap_sll got %0h want 6", obs_q[1].data); end
    end
    model_clear();
  endtask

  task automatic test_random();
    logic [1:0] pv;
    logic [1:0] want;
    logic       ready_any;
    int         bad;
    do_reset();
    pv = 2'b00;
    bad = 0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] && $urandom_range(0, 2) != 0) begin
          pv[p] = 1'b1;
          set_port(p, word_t'({$urandom, $urandom}), word_t'({$urandom, $urandom}), op_t'($urandom_range(0, 9)));
        end
      end
      bus.req_valid = pv;
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      // Two slots: a new op fits unless both are occupied and the head is not leaving.
      ready_any = (inflight < 2) || bus.rsp_ready;
      if (!ready_any) want = 2'b00;
      else if (pv == 2'b11) want = (mdl_last == 1) ? 2'b01 : 2'b10;
      else want = pv;
      tick();
      checks++;
      if (smp_ready !== want) begin
        errors++;
        if (bad < 10) $display("FAIL rand_ready cycle %0d got %b want %b", c, smp_ready, want);
        bad++;
      end
      pv = pv & ~smp_ready;
    end
    drain();
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      checks++; if (obs_q[k] !== exp_q[k]) begin errors++; $display("FAIL rand_rsp%0d got %0h want %0h", k, obs_q[k], exp_q[k]); end
    end
    model_clear();
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_back_to_back();
    test_backpressure();
    test_async_reset();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
